// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC and the imem req/ready handshake,
// producing the IF/ID instruction word, PC+4 and address-error exception code.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        FREEZE,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] out_IR,
    output logic [31:0] out_PCp4,
    output logic [4:0]  out_X,
    output logic        fetch_busy
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_ir_q, hold_ir_d;
    logic        bad, flush, fetching, done;
    logic [31:0] pc_p4, next_pc;

    always_comb begin
        bad        = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI);
        flush      = exc_req | eret_req;
        pc_p4      = pc_q + 32'd4;
        next_pc    = redirect_valid ? redirect_pc : pc_p4;
        fetching   = !flush && state_q == FETCH && !bad;
        done       = fetching && imem_ready;
        imem_req   = fetching;
        imem_addr  = pc_q;
        fetch_busy = fetching && !imem_ready;
        out_PCp4   = pc_p4;
        out_X      = (!flush && state_q == FETCH && bad) ? 5'd4 : 5'd0;
        out_IR     = flush ? 32'd0 : state_q == HOLD ? hold_ir_q : done ? imem_rdata : 32'd0;
    end

    // A completed fetch under FREEZE parks the word in hold_ir instead of re-fetching.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        hold_ir_d = hold_ir_q;
        if (exc_req) begin
            pc_d    = EXC_PC;
            state_d = FETCH;
        end else if (eret_req) begin
            pc_d    = epc_in;
            state_d = FETCH;
        end else if (state_q == HOLD) begin
            pc_d    = FREEZE ? pc_q : next_pc;
            state_d = FREEZE ? HOLD : FETCH;
        end else if (bad) begin
            pc_d    = FREEZE ? pc_q : next_pc;
        end else if (imem_ready) begin
            pc_d      = FREEZE ? pc_q : next_pc;
            state_d   = FREEZE ? HOLD : FETCH;
            hold_ir_d = FREEZE ? imem_rdata : hold_ir_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            state_q   <= FETCH;
            hold_ir_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            hold_ir_q <= hold_ir_d;
        end
    end
endmodule
